// File: rtl/dct_coef_quantizer_pkg.sv
// Shared types and constants for the DCT coefficient quantizer.
// Optional run-length skipping of zero coefficients is enabled with DCTQ_RLE_EN.
package dct_q_pkg;

    localparam int CW = 8;   // signed coefficient width
    localparam int RW = 8;   // unsigned Q0.8 reciprocal width
    localparam int SW = 3;   // qscale shift width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_CAPT = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    // Fixed per-index reciprocal table, Q0.8.
    function automatic logic [RW-1:0] recip_of(input logic [2:0] idx);
        case (idx)
            3'd0: recip_of = RW'(32);
            3'd1: recip_of = RW'(45);
            3'd2: recip_of = RW'(51);
            3'd3: recip_of = RW'(64);
            3'd4: recip_of = RW'(64);
            3'd5: recip_of = RW'(80);
            3'd6: recip_of = RW'(91);
            3'd7: recip_of = RW'(102);
            default: recip_of = RW'(0);
        endcase
    endfunction

endpackage

// File: rtl/dct_coef_quantizer_if.sv
// Control, DCT read port and output stream of the quantizer.
// out_run exists only when DCTQ_RLE_EN is defined.
interface dct_coef_quantizer_if;
    import dct_q_pkg::*;

    logic                 start;
    logic [SW-1:0]        qscale;
    logic                 busy;
    logic [2:0]           coef_add;
    logic                 coef_oe;
    logic signed [CW-1:0] coef_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [CW-1:0] out_data;
    logic [2:0]           out_idx;
    logic                 out_last;
`ifdef DCTQ_RLE_EN
    logic [2:0]           out_run;

    modport master (output start, qscale, coef_in, out_ready,
                    input  busy, coef_add, coef_oe, out_valid, out_data, out_idx, out_last, out_run);
    modport slave  (input  start, qscale, coef_in, out_ready,
                    output busy, coef_add, coef_oe, out_valid, out_data, out_idx, out_last, out_run);
`else
    modport master (output start, qscale, coef_in, out_ready,
                    input  busy, coef_add, coef_oe, out_valid, out_data, out_idx, out_last);
    modport slave  (input  start, qscale, coef_in, out_ready,
                    output busy, coef_add, coef_oe, out_valid, out_data, out_idx, out_last);
`endif

endinterface

// File: rtl/dct_coef_quantizer_mul.sv
// Combinational quantizer core: signed multiply by Q0.8 reciprocal,
// round half up, then arithmetic right shift by qscale.
module dct_q_mul
    import dct_q_pkg::*;
(
    input  logic signed [CW-1:0] coef_i,
    input  logic [RW-1:0]        recip_i,
    input  logic [SW-1:0]        shift_i,
    output logic signed [CW-1:0] result_o
);
    localparam int PW = 2 * CW;

    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] recip_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] q;
    logic signed [PW-1:0] sh;

    // Reciprocal is below 256, so the product and rounding never overflow PW bits.
    always_comb begin
        coef_x   = PW'(coef_i);
        recip_x  = $signed({{(PW-RW){1'b0}}, recip_i});
        prod     = coef_x * recip_x;
        rnd      = prod + PW'(128);
        q        = rnd >>> 8;
        sh       = q >>> shift_i;
        result_o = CW'(sh);
    end

endmodule

// File: rtl/dct_coef_quantizer.sv
// Walks the DCT read port over indices 0..7, quantizes each coefficient
// and emits it on a valid/ready stream. Zero skipping with run counts is
// enabled by defining DCTQ_RLE_EN.
module dct_coef_quantizer
    import dct_q_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dct_coef_quantizer_if.slave bus
);
    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [SW-1:0]        qs_q, qs_d;
    logic signed [CW-1:0] data_q, data_d;
    logic [2:0]           oidx_q, oidx_d;
    logic                 last_q, last_d;
    logic [2:0]           run_q, run_d;
    logic [2:0]           orun_q, orun_d;
    logic signed [CW-1:0] qres;
    logic                 skip;

    dct_q_mul u_mul (
        .coef_i   (bus.coef_in),
        .recip_i  (recip_of(idx_q)),
        .shift_i  (qs_q),
        .result_o (qres)
    );

`ifdef DCTQ_RLE_EN
    assign skip = (qres == '0) && (idx_q != 3'd7);
`else
    assign skip = 1'b0;
`endif

    // State and datapath registers; reset drops any block in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            qs_q    <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            run_q   <= '0;
            orun_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            qs_q    <= qs_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            run_q   <= run_d;
            orun_q  <= orun_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        qs_d    = qs_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        run_d   = run_q;
        orun_d  = orun_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ADDR;
                    idx_d   = '0;
                    qs_d    = bus.qscale;
                    run_d   = '0;
                end
            end
            S_ADDR: state_d = S_CAPT;
            S_CAPT: begin
                if (skip) begin
                    state_d = S_ADDR;
                    idx_d   = idx_q + 3'd1;
                    run_d   = run_q + 3'd1;
                end else begin
                    state_d = S_EMIT;
                    data_d  = qres;
                    oidx_d  = idx_q;
                    last_d  = (idx_q == 3'd7);
                    orun_d  = run_q;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    run_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ADDR;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the DCT address tracks the walk index.
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.coef_oe   = (state_q != S_IDLE);
        bus.coef_add  = idx_q;
        bus.out_valid = (state_q == S_EMIT);
        bus.out_data  = data_q;
        bus.out_idx   = oidx_q;
        bus.out_last  = last_q;
`ifdef DCTQ_RLE_EN
        bus.out_run   = orun_q;
`endif
    end

    logic unused_orun;
    assign unused_orun = ^orun_q;

endmodule

// File: tb/tb_dct_coef_quantizer.sv
// Scoreboard bench for dct_coef_quantizer; covers DCTQ_RLE_EN when defined.
module tb_dct_coef_quantizer;

    typedef struct {
        int data;
        int idx;
        int last;
        int run;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    beat_t sb[$];
    beat_t mon_e;
    logic signed [7:0] dct_mem [8];
    int   recip_tab [8] = '{32, 45, 51, 64, 64, 80, 91, 102};
    int   fv, bl;

    dct_coef_quantizer_if bus();

    dct_coef_quantizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // DCT model: registered-free read port driven by the walked address.
    always_comb bus.coef_in = bus.coef_oe ? dct_mem[bus.coef_add] : 8'sd0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int qmodel(input int c, input int i, input int qs);
        int p;
        p = (c * recip_tab[i] + 128) >>> 8;
        return p >>> qs;
    endfunction

    task automatic push_block(input int qs);
        int run;
        int v;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            v = qmodel(int'(dct_mem[i]), i, qs);
`ifdef DCTQ_RLE_EN
            if (v == 0 && i != 7) begin
                run++;
                continue;
            end
`endif
            sb.push_back('{v, i, (i == 7) ? 1 : 0, run});
            run = 0;
        end
    endtask

    // Pops the expected beat at every accepted handshake.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", int'(bus.out_data), mon_e.data);
                check("out_idx", int'(bus.out_idx), mon_e.idx);
                check("out_last", int'(bus.out_last), mon_e.last);
`ifdef DCTQ_RLE_EN
                check("out_run", int'(bus.out_run), mon_e.run);
`endif
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_coef_oe"}, int'(bus.coef_oe), 0);
        check({tag, "_coef_add"}, int'(bus.coef_add), 0);
        check({tag, "_valid"}, int'(bus.out_valid), 0);
        check({tag, "_data"}, int'(bus.out_data), 0);
        check({tag, "_idx"}, int'(bus.out_idx), 0);
        check({tag, "_last"}, int'(bus.out_last), 0);
    endtask

    // One block: optional stall on stall_idx, extra start at edge extra_n,
    // reset abort when abort_idx is presented.
    task automatic run_block(input int qs, input int stall_idx, input int extra_n,
                             input int abort_idx, output int first_v, output int busy_n);
        int n;
        bit stalled;
        int sd, si;
        push_block(qs);
        bus.qscale = 3'(qs);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.qscale = 3'd0;
        n = 0;
        first_v = -1;
        busy_n = -1;
        stalled = 0;
        while (bus.busy && n < 300) begin
            if (bus.out_valid && first_v < 0) first_v = n;
            if (bus.out_valid && int'(bus.out_idx) == abort_idx) begin
                reset = 1'b1;
                tick();
                check_reset_vals("abort");
                reset = 1'b0;
                check("abort_pending", sb.size(), 7 - abort_idx + 1);
                sb.delete();
                return;
            end
            if (bus.out_valid && int'(bus.out_idx) == stall_idx && !stalled) begin
                stalled = 1;
                sd = int'(bus.out_data);
                si = int'(bus.out_idx);
                bus.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    n++;
                    check("stall_valid", int'(bus.out_valid), 1);
                    check("stall_data", int'(bus.out_data), sd);
                    check("stall_idx", int'(bus.out_idx), si);
                    check("stall_coef_add", int'(bus.coef_add), stall_idx);
                end
                bus.out_ready = 1'b1;
            end
            if (n == extra_n) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            n++;
        end
        busy_n = n;
        if (n >= 300) check("block_timeout", 1, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.qscale    = 3'd0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) dct_mem[i] = 8'sd100;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_vals("reset");

        // Idle: no start, nothing moves.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle", int'({bus.busy, bus.coef_oe, bus.out_valid}), 0);
        end

        // All-100 block, ready high; cycle timing of first valid and busy drop.
        run_block(0, -1, -1, -1, fv, bl);
        check("first_valid_edge", fv, 2);
        check("busy_low_edge", bl, 24);
        check("idle_after", int'(bus.coef_oe), 0);

        // Negative coefficients with and without shift, and -1 rounding to 0.
        for (int i = 0; i < 8; i++) dct_mem[i] = -8'sd100;
        run_block(0, -1, -1, -1, fv, bl);
        run_block(2, -1, -1, -1, fv, bl);
        for (int i = 0; i < 8; i++) dct_mem[i] = -8'sd1;
        run_block(0, -1, -1, -1, fv, bl);

        // Extremes and mixed signs.
        dct_mem = '{8'sd127, -8'sd128, 8'sd37, -8'sd5, 8'sd2, -8'sd64, 8'sd90, -8'sd127};
        run_block(1, -1, -1, -1, fv, bl);
        run_block(7, -1, -1, -1, fv, bl);

        // Backpressure on idx2.
        for (int i = 0; i < 8; i++) dct_mem[i] = 8'sd100;
        run_block(0, 2, -1, -1, fv, bl);

        // Second start mid-block, then reset during idx4 presentation.
        run_block(0, -1, 5, 4, fv, bl);
        tick();
        check_reset_vals("post_abort");
        for (int i = 0; i < 8; i++) dct_mem[i] = 8'(i * 10 - 35);
        run_block(0, -1, -1, -1, fv, bl);
        check("restart_first_valid", fv, 2);

        // Zero-heavy pattern: every beat in default build, skipped runs with RLE.
        dct_mem = '{8'sd100, 8'sd0, 8'sd0, 8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        run_block(0, -1, -1, -1, fv, bl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
